// File: rtl/jpeg_pkg.sv
// jpeg_pkg: component ids and block sizing shared by the scheduler, DCT and Huffman blocks.
package jpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    function automatic int mcu_bits(input int pixel_bitwidth, input int mcu_size);
        return pixel_bitwidth * mcu_size * mcu_size;
    endfunction

endpackage

// File: rtl/mcu_slot_fifo.sv
// mcu_slot_fifo: 2-entry FIFO; a push into a full slot is dropped unless the head leaves in the same cycle.
module mcu_slot_fifo #(
    parameter int WIDTH = 513
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             overflow
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr, wr_ptr, do_push, do_pop;

    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && (count != 2'd2 || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= !wr_ptr;
            if (do_pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
            if (push && !do_push) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/mcu_component_scheduler.sv
// mcu_component_scheduler: interleaves buffered Y/Cb/Cr MCUs in strict Y->Cb->Cr order into one pipeline.
module mcu_component_scheduler
    import jpeg_pkg::*;
#(
    parameter int PIXEL_BITWIDTH     = 8,
    parameter int MCU_SIZE           = 8,
    parameter int MCU_COUNT_BITWIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic [MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH-1:0] i_y_mcu,
    input  logic                                       i_y_valid,
    input  logic                                       i_y_last,
    input  logic [MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH-1:0] i_cb_mcu,
    input  logic                                       i_cb_valid,
    input  logic                                       i_cb_last,
    input  logic [MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH-1:0] i_cr_mcu,
    input  logic                                       i_cr_valid,
    input  logic                                       i_cr_last,
    input  logic                                       i_ready,
    output logic [MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH-1:0] o_mcu,
    output logic [1:0]                                 o_comp,
    output logic                                       o_valid,
    output logic                                       o_last,
    output logic                                       o_wait,
    output logic [MCU_COUNT_BITWIDTH-1:0]              o_mcu_count,
    output logic                                       o_overflow
);
    localparam int MB = mcu_bits(PIXEL_BITWIDTH, MCU_SIZE);
    localparam int W  = MB + 1;
    localparam logic [MCU_COUNT_BITWIDTH-1:0] ONE = 1;

    logic [W-1:0] din [3];
    logic [W-1:0] dout [3];
    logic [1:0]   cnt [3];
    logic [2:0]   push, pop, ovf;
    logic [W-1:0] head;
    logic [1:0]   head_cnt;
    logic         hs;
    comp_t        state_q, state_d;

    assign din[0] = {i_y_mcu, i_y_last};
    assign din[1] = {i_cb_mcu, i_cb_last};
    assign din[2] = {i_cr_mcu, i_cr_last};
    assign push   = {i_cr_valid, i_cb_valid, i_y_valid};

    for (genvar i = 0; i < 3; i++) begin : g_slot
        mcu_slot_fifo #(.WIDTH(W)) u_slot (
            .clk(clk), .n_rst(n_rst), .push(push[i]), .pop(pop[i]), .din(din[i]),
            .dout(dout[i]), .count(cnt[i]), .overflow(ovf[i])
        );
    end

    // Outputs depend only on registered slot/state, so i_ready never reaches o_valid.
    always_comb begin
        head     = state_q == COMP_CB ? dout[1] : state_q == COMP_CR ? dout[2] : dout[0];
        head_cnt = state_q == COMP_CB ? cnt[1] : state_q == COMP_CR ? cnt[2] : cnt[0];
        o_valid  = head_cnt != 2'd0;
        o_mcu    = o_valid ? head[W-1:1] : '0;
        o_last   = o_valid && state_q == COMP_CR && head[0];
        hs       = o_valid && i_ready;
        pop      = hs ? 3'b001 << state_q : 3'b000;
        state_d  = !hs ? state_q : state_q == COMP_Y ? COMP_CB : state_q == COMP_CB ? COMP_CR : COMP_Y;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= COMP_Y;
            o_mcu_count <= '0;
        end else begin
            state_q <= state_d;
            if (hs && state_q == COMP_CR) o_mcu_count <= o_last ? '0 : o_mcu_count + ONE;
        end
    end

    assign o_comp     = state_q;
    assign o_wait     = cnt[0] != 2'd0 || cnt[1] != 2'd0 || cnt[2] != 2'd0;
    assign o_overflow = |ovf;
endmodule

// File: tb/tb_mcu_component_scheduler.sv
// tb_mcu_component_scheduler: directed and random stimulus checked against a queue-based reference model.
module tb_mcu_component_scheduler;
    localparam int MB = 512;

    logic          clk = 1'b0, n_rst = 1'b0;
    logic [MB-1:0] i_y_mcu = '0, i_cb_mcu = '0, i_cr_mcu = '0;
    logic          i_y_valid = 0, i_y_last = 0, i_cb_valid = 0, i_cb_last = 0;
    logic          i_cr_valid = 0, i_cr_last = 0, i_ready = 0;
    logic [MB-1:0] o_mcu;
    logic [1:0]    o_comp;
    logic          o_valid, o_last, o_wait, o_overflow;
    logic [15:0]   o_mcu_count;

    mcu_component_scheduler dut (
        .clk(clk), .n_rst(n_rst),
        .i_y_mcu(i_y_mcu), .i_y_valid(i_y_valid), .i_y_last(i_y_last),
        .i_cb_mcu(i_cb_mcu), .i_cb_valid(i_cb_valid), .i_cb_last(i_cb_last),
        .i_cr_mcu(i_cr_mcu), .i_cr_valid(i_cr_valid), .i_cr_last(i_cr_last),
        .i_ready(i_ready), .o_mcu(o_mcu), .o_comp(o_comp), .o_valid(o_valid),
        .o_last(o_last), .o_wait(o_wait), .o_mcu_count(o_mcu_count), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: one bounded queue of {block, last} per component, plus the component expected next.
    logic [MB:0] q [3][$];
    int          st = 0;
    logic [15:0] cnt = 0;
    logic        ovf = 0;
    int          n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MB-1:0] rnd_mcu();
        logic [MB-1:0] m;
        for (int k = 0; k < MB / 32; k++) m[k*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic step(input logic [2:0] v, input logic [2:0] l, input logic rdy);
        logic [MB-1:0] m [3];
        logic          ev, wt;
        logic [MB:0]   h;
        for (int c = 0; c < 3; c++) m[c] = rnd_mcu();
        {i_y_mcu, i_cb_mcu, i_cr_mcu} = {m[0], m[1], m[2]};
        {i_cr_valid, i_cb_valid, i_y_valid} = v;
        {i_cr_last, i_cb_last, i_y_last} = l;
        i_ready = rdy;
        ev = q[st].size() != 0;
        h  = ev ? q[st][0] : '0;
        wt = q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0;
        chk("valid", o_valid, ev);
        chk("comp", o_comp, st);
        chk("last", o_last, ev && st == 2 && h[0]);
        chk("wait", o_wait, wt);
        chk("overflow", o_overflow, ovf);
        chk("mcu_count", o_mcu_count, cnt);
        if (ev) chk("mcu", o_mcu, h[MB:1]);
        @(posedge clk); #1;
        if (ev && rdy) begin
            void'(q[st].pop_front());
            if (st == 2) cnt = h[0] ? 16'd0 : cnt + 16'd1;
            st = (st + 1) % 3;
        end
        for (int c = 0; c < 3; c++)
            if (v[c]) begin
                if (q[c].size() < 2) q[c].push_back({m[c], l[c]});
                else ovf = 1'b1;
            end
        {i_cr_valid, i_cb_valid, i_y_valid} = 3'b000;
        {i_cr_last, i_cb_last, i_y_last} = 3'b000;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(3'b000, 3'b000, rdy);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mcu", o_mcu, '0);
        chk("rst_comp", o_comp, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_wait", o_wait, 0);
        chk("rst_count", o_mcu_count, 0);
        chk("rst_overflow", o_overflow, 0);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) q[c].delete();
        st = 0; cnt = 0; ovf = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        // one MCU, all components in the same cycle
        step(3'b111, 3'b000, 1'b1);
        idle(4, 1'b1);
        // Cr arrives early and must wait for Y and Cb
        step(3'b100, 3'b000, 1'b1);
        idle(3, 1'b1);
        step(3'b011, 3'b000, 1'b1);
        idle(4, 1'b1);
        // back-pressure: Y block held stable
        step(3'b111, 3'b000, 1'b0);
        idle(10, 1'b0);
        idle(4, 1'b1);
        // two MCUs back to back fill the slots
        step(3'b111, 3'b000, 1'b1);
        step(3'b111, 3'b000, 1'b1);
        idle(8, 1'b1);
        // third push into full slots drops and sets the sticky flag
        step(3'b111, 3'b000, 1'b0);
        step(3'b111, 3'b000, 1'b0);
        step(3'b111, 3'b000, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);
        do_reset();
        // frame end on the second MCU
        step(3'b111, 3'b000, 1'b1);
        step(3'b111, 3'b111, 1'b1);
        idle(8, 1'b1);
        // reset in mid-stream, then a fresh frame from Y
        step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b1);
        do_reset();
        idle(3, 1'b1);
        step(3'b111, 3'b000, 1'b1);
        idle(4, 1'b1);
        // random traffic
        for (int k = 0; k < 400; k++)
            step({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
                 $urandom_range(0, 3) != 0);
        idle(12, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mcu_component_scheduler.md
Name: mcu_component_scheduler

Overview:
- Sequences the Y, Cb and Cr MCU streams into the single shared DCT/quantiser pipeline.
- Each of the three component streams comes from its own MCU splitter instance.
- Enforces the JPEG 4:4:4 interleave order Y -> Cb -> Cr per MCU and buffers each component in a 2-entry slot.
- Throttles the upstream pixel stream via o_wait when any slot holds data.
- Forwards frame-end to the downstream pipeline.

Parameters:
- PIXEL_BITWIDTH, 8, bits per sample
- MCU_SIZE, 8, MCU edge length in samples
- MCU_COUNT_BITWIDTH, 16, width of per-frame MCU counter

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- i_y_mcu  in  MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH  Y block, row-major, element [0][0] in MSBs
- i_y_valid  in  1  single-cycle pulse, i_y_mcu valid
- i_y_last  in  1  frame's final MCU, qualified by i_y_valid
- i_cb_mcu, i_cb_valid, i_cb_last  in  same widths  Cb stream
- i_cr_mcu, i_cr_valid, i_cr_last  in  same widths  Cr stream
- i_ready  in  1  shared pipeline accepts o_mcu this cycle
- o_mcu  out  MCU_SIZE*MCU_SIZE*PIXEL_BITWIDTH  block to pipeline
- o_comp  out  2  component id of o_mcu: 0=Y, 1=Cb, 2=Cr
- o_valid  out  1  o_mcu valid
- o_last  out  1  with o_valid: final Cr block of frame
- o_wait  out  1  stall to upstream stream/splitters
- o_mcu_count  out  MCU_COUNT_BITWIDTH  completed MCUs (Y+Cb+Cr) in current frame
- o_overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset values: all outputs 0; slots empty; FSM in SEND_Y.
- Slots: one per component.
  - 2-entry FIFO of {mcu, last}.
  - Push on i_x_valid; pop on handshake (o_valid & i_ready) in that component's state.
- Push/pop in the same cycle on the same slot are legal at any occupancy; count is unchanged.
- Push when count==2 without a simultaneous pop:
  - Entry dropped; o_overflow set (cleared only by reset).
  - Count stays 2.
- o_wait = registered OR of (count != 0) over all slots; it updates the cycle after a push or pop.
  - The second slot entry absorbs the one MCU already in flight in the splitter when o_wait rises.
- FSM states SEND_Y, SEND_CB, SEND_CR:
  - In each state: o_valid = (that slot's count != 0); o_mcu/o_last come from the slot head; o_comp = state.
  - On handshake, advance: SEND_Y -> SEND_CB -> SEND_CR -> SEND_Y.
  - Otherwise hold the state.
- Never skip a component: a Cb or Cr entry waits even if its slot is full and the Y slot is empty.
- AXI-style hold: once o_valid=1, o_mcu, o_comp and o_last stay stable until i_ready.
- No combinational path from i_ready to o_valid.
- o_last = head.last in SEND_CR only; forced to 0 in SEND_Y and SEND_CB.
- Latency: push at cycle N -> o_valid earliest at cycle N+1 (slot is registered).
- o_mcu_count:
  - +1 on each Cr handshake.
  - On a Cr handshake with o_last=1, resets to 0 on the next cycle instead of incrementing.
  - Wraps modulo 2^MCU_COUNT_BITWIDTH.
- Simultaneous pushes on all three slots in one cycle are normal and must all be accepted.
- Reset mid-frame: slots flushed, FSM to SEND_Y, counter and flags cleared; no partial block emitted afterwards.

Decomposition:
- Package jpeg_pkg:
  - comp_t enum (COMP_Y=2'd0, COMP_CB=2'd1, COMP_CR=2'd2).
  - function mcu_bits(PIXEL_BITWIDTH, MCU_SIZE).
  - Shared with the DCT and Huffman blocks.
- Sub-module mcu_slot_fifo:
  - Parameterised width, fixed depth 2.
  - Ports: push, pop, din, dout, count[1:0], overflow.
  - Instantiated three times.

Test Plan:
- Single MCU, all three valid pulses in the same cycle, i_ready=1 -> o_valid for 3 consecutive cycles, o_comp 0,1,2; o_last=0; o_mcu_count=1; o_wait high 1 cycle after the push, low after the Cr pop.
- Cr pushed 3 cycles before Y and Cb, i_ready=1 -> nothing emitted until Y arrives; output order still Y, Cb, Cr.
- i_ready=0 for 10 cycles with the Y block presented -> o_mcu and o_comp=0 held constant; emission resumes the cycle i_ready=1.
- Two MCUs pushed back-to-back (slots reach count 2), i_ready=1 -> 6 beats in order Y,Cb,Cr,Y,Cb,Cr; o_overflow=0.
- Third push to a slot already holding 2 with i_ready=0 -> o_overflow=1 and stays 1; the later drain emits only 2 blocks for that component.
- Final MCU with last=1 on all streams -> o_last=1 only on the Cr beat; o_mcu_count reads 0 the cycle after; assert n_rst mid-stream -> all outputs 0 and the next frame starts at SEND_Y.
